icache_direct: RTL and testbench

Direct-mapped, read-only instruction cache. It is the responder on the datapath's instruction-fetch port: it answers `imemREN`/`imemaddr` with `ihit`/`imemload`, and on a miss it fetches one word from the memory-side arbiter. It sits between the datapath and the memory controller, wired to the `icache` modport of `datapath_cache_if` on the datapath side and to the instruction channel of the cache/memory interface on the other side.

---
 rtl/icache_direct.sv | 195 +++++++++++++++++++
 tb/tb_icache_direct.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache.
// One 32-bit word per frame. Hits are answered combinationally in IDLE;
// a miss records the word address and moves to FETCH, which holds a memory
// read request until the memory side drops iwait. A fill is never aborted
// except by RST. hitcnt and misscnt are saturating event counters.
module icache_direct #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iwait,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  output logic [31:0] hitcnt,
  output logic [31:0] misscnt
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  // Frame storage: valid bits are reset, tag/data are don't-care until filled.
  logic [SETS-1:0]     valid_r;
  logic [TAGW-1:0]     tag_r  [SETS];
  logic [31:0]         data_r [SETS];

  // Word address of the outstanding miss (byte offset is never needed).
  logic [29:0]         miss_word_r;

  logic [31:0]         hitcnt_r;
  logic [31:0]         misscnt_r;

  logic [IDXW-1:0]     req_idx_s;
  logic [TAGW-1:0]     req_tag_s;
  logic [IDXW-1:0]     miss_idx_s;
  logic [TAGW-1:0]     miss_tag_s;
  logic                ihit_s;
  logic                start_miss_s;
  logic                fill_s;
  logic                unused_offset_s;

  // The byte offset of the fetch address does not select anything.
  assign unused_offset_s = &{1'b0, imemaddr[1:0]};

  assign req_idx_s  = imemaddr[IDXW+1:2];
  assign req_tag_s  = imemaddr[31:IDXW+2];
  assign miss_idx_s = miss_word_r[IDXW-1:0];
  assign miss_tag_s = miss_word_r[29:IDXW];

  // Lookup: hit only in IDLE, outside reset, on a valid frame with matching tag.
  always_comb begin
    ihit_s       = 1'b0;
    start_miss_s = 1'b0;
    if (!RST && (state_r == IDLE) && imemREN) begin
      if (valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s)) begin
        ihit_s       = 1'b1;
        start_miss_s = 1'b0;
      end else begin
        ihit_s       = 1'b0;
        start_miss_s = 1'b1;
      end
    end else begin
      ihit_s       = 1'b0;
      start_miss_s = 1'b0;
    end
  end

  // A fill completes on the first FETCH cycle with iwait low; reset discards it.
  always_comb begin
    fill_s = 1'b0;
    if (!RST && (state_r == FETCH) && !iwait) begin
      fill_s = 1'b1;
    end else begin
      fill_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE/FETCH controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_miss_s) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (!iwait) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the word address of a new miss; held for the whole fetch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      miss_word_r <= 30'd0;
    end else if (start_miss_s) begin
      miss_word_r <= imemaddr[31:2];
    end else begin
      miss_word_r <= miss_word_r;
    end
  end

  // Valid bits: cleared by reset, set by a completed fill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_r <= '0;
    end else if (fill_s) begin
      valid_r[miss_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data arrays: written only by a completed fill, never reset.
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      tag_r[miss_idx_s]  <= miss_tag_s;
      data_r[miss_idx_s] <= iload;
    end
  end

  // Saturating hit and fill counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hitcnt_r  <= 32'd0;
      misscnt_r <= 32'd0;
    end else begin
      if (ihit_s && (hitcnt_r != 32'hFFFF_FFFF)) begin
        hitcnt_r <= hitcnt_r + 32'd1;
      end else begin
        hitcnt_r <= hitcnt_r;
      end
      if (fill_s && (misscnt_r != 32'hFFFF_FFFF)) begin
        misscnt_r <= misscnt_r + 32'd1;
      end else begin
        misscnt_r <= misscnt_r;
      end
    end
  end

  // Output drive: memory request depends on state only (masked during reset).
  always_comb begin
    ihit     = ihit_s;
    imemload = 32'd0;
    iREN     = 1'b0;
    iaddr    = 32'd0;
    if (ihit_s) begin
      imemload = data_r[req_idx_s];
    end else begin
      imemload = 32'd0;
    end
    if (!RST && (state_r == FETCH)) begin
      iREN  = 1'b1;
      iaddr = {miss_word_r, 2'b00};
    end else begin
      iREN  = 1'b0;
      iaddr = 32'd0;
    end
  end

  assign hitcnt  = hitcnt_r;
  assign misscnt = misscnt_r;

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural cache model held as "which word address is
// resident in each frame" plus a single outstanding-fetch record.
module tb_icache_direct;
  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iwait;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic [31:0] hitcnt;
  logic [31:0] misscnt;

  int num_checks   = 0;
  int num_failures = 0;

  // Reference model state.
  bit          m_valid    [SETS];
  logic [31:0] m_resident [SETS];
  bit          m_busy;
  logic [31:0] m_addr;
  logic [31:0] m_hits;
  logic [31:0] m_fills;

  // Observations from the most recent cycle, for directed constant checks.
  logic        last_ihit;
  logic [31:0] last_load;
  logic        last_iren;
  logic [31:0] last_iaddr;
  logic [31:0] last_hitcnt;
  logic [31:0] last_misscnt;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign iload = mem_fn(iaddr);

  icache_direct #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iwait    (iwait),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .hitcnt   (hitcnt),
    .misscnt  (misscnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic do_cycle(input bit rst, input bit ren, input logic [31:0] addr, input bit wt);
    bit          e_hit;
    bit          e_iren;
    logic [31:0] e_load;
    logic [31:0] e_iaddr;
    logic [31:0] waddr;
    int          idx;
    int          fidx;
    @(negedge CLK);
    RST      = rst;
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    #1;
    waddr   = addr & 32'hFFFF_FFFC;
    idx     = int'((addr >> 2) % SETS);
    e_hit   = !rst && !m_busy && ren && m_valid[idx] && (m_resident[idx] == waddr);
    e_load  = e_hit ? mem_fn(waddr) : 32'd0;
    e_iren  = !rst && m_busy;
    e_iaddr = e_iren ? m_addr : 32'd0;
    check_eq("ihit",     {31'd0, ihit}, {31'd0, e_hit});
    check_eq("imemload", imemload,      e_load);
    check_eq("iREN",     {31'd0, iREN}, {31'd0, e_iren});
    check_eq("iaddr",    iaddr,         e_iaddr);
    check_eq("hitcnt",   hitcnt,        m_hits);
    check_eq("misscnt",  misscnt,       m_fills);
    last_ihit    = ihit;
    last_load    = imemload;
    last_iren    = iREN;
    last_iaddr   = iaddr;
    last_hitcnt  = hitcnt;
    last_misscnt = misscnt;
    @(posedge CLK);
    if (rst) begin
      m_busy  = 1'b0;
      m_hits  = 32'd0;
      m_fills = 32'd0;
      for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    end else begin
      if (e_hit && (m_hits != 32'hFFFF_FFFF)) m_hits = m_hits + 32'd1;
      if (m_busy) begin
        if (!wt) begin
          fidx             = int'((m_addr >> 2) % SETS);
          m_valid[fidx]    = 1'b1;
          m_resident[fidx] = m_addr;
          if (m_fills != 32'hFFFF_FFFF) m_fills = m_fills + 32'd1;
          m_busy           = 1'b0;
        end
      end else if (ren && !e_hit) begin
        m_busy = 1'b1;
        m_addr = waddr;
      end
    end
  endtask

  initial begin
    int n;
    logic [31:0] a;

    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; iwait = 1'b1;
    m_busy = 1'b0; m_hits = 32'd0; m_fills = 32'd0; m_addr = 32'd0;
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_resident[i] = 32'd0;
    end
    repeat (2) @(posedge CLK);

    // Reset state, with a request present that must be ignored.
    do_cycle(1'b1, 1'b1, 32'h40, 1'b0);
    check_eq("rst_ihit", {31'd0, last_ihit}, 32'd0);
    check_eq("rst_iren", {31'd0, last_iren}, 32'd0);

    // Cold miss: three wait cycles, then data.
    do_cycle(1'b0, 1'b1, 32'h40, 1'b1);
    check_eq("cold_c0_ihit", {31'd0, last_ihit}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      do_cycle(1'b0, 1'b1, 32'h40, (c == 4) ? 1'b0 : 1'b1);
      check_eq("cold_iren",  {31'd0, last_iren}, 32'd1);
      check_eq("cold_iaddr", last_iaddr, 32'h40);
    end
    do_cycle(1'b0, 1'b1, 32'h40, 1'b1);
    check_eq("cold_hit",     {31'd0, last_ihit}, 32'd1);
    check_eq("cold_load",    last_load, 32'hDEAD_BEEF);
    check_eq("cold_misscnt", last_misscnt, 32'd1);

    // Warm hits, including a non-zero byte offset.
    do_cycle(1'b0, 1'b1, 32'h42, 1'b1);
    check_eq("warm_off_hit",  {31'd0, last_ihit}, 32'd1);
    check_eq("warm_off_load", last_load, 32'hDEAD_BEEF);
    do_cycle(1'b0, 1'b1, 32'h40, 1'b1);
    do_cycle(1'b0, 1'b1, 32'h43, 1'b1);
    do_cycle(1'b0, 1'b0, 32'h40, 1'b1);
    check_eq("warm_hitcnt", last_hitcnt, 32'd4);
    check_eq("idle_noren",  {31'd0, last_ihit}, 32'd0);

    // Conflict: 0x80 evicts 0x40 from index 0, then 0x40 misses again.
    do_cycle(1'b0, 1'b1, 32'h80, 1'b0);
    check_eq("conf_80_miss", {31'd0, last_ihit}, 32'd0);
    do_cycle(1'b0, 1'b1, 32'h80, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h80, 1'b0);
    check_eq("conf_80_hit", {31'd0, last_ihit}, 32'd1);
    do_cycle(1'b0, 1'b1, 32'h40, 1'b0);
    check_eq("conf_40_miss", {31'd0, last_ihit}, 32'd0);
    do_cycle(1'b0, 1'b1, 32'h40, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h40, 1'b0);
    check_eq("conf_40_hit", {31'd0, last_ihit}, 32'd1);
    check_eq("conf_misscnt", last_misscnt, 32'd3);

    // Address change mid-fetch: fill still targets 0x10.
    do_cycle(1'b0, 1'b1, 32'h10, 1'b1);
    do_cycle(1'b0, 1'b1, 32'h14, 1'b1);
    check_eq("chg_iaddr1", last_iaddr, 32'h10);
    do_cycle(1'b0, 1'b1, 32'h14, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h14, 1'b0);
    check_eq("chg_14_miss", {31'd0, last_ihit}, 32'd0);
    do_cycle(1'b0, 1'b1, 32'h14, 1'b0);
    check_eq("chg_iaddr2", last_iaddr, 32'h14);
    do_cycle(1'b0, 1'b1, 32'h10, 1'b0);
    check_eq("chg_10_hit", {31'd0, last_ihit}, 32'd1);

    // Reset mid-fetch, with iwait low on the reset cycle.
    do_cycle(1'b0, 1'b1, 32'h100, 1'b1);
    do_cycle(1'b0, 1'b1, 32'h100, 1'b1);
    do_cycle(1'b1, 1'b1, 32'h100, 1'b0);
    do_cycle(1'b0, 1'b0, 32'h100, 1'b0);
    check_eq("rstf_iren",    {31'd0, last_iren}, 32'd0);
    check_eq("rstf_misscnt", last_misscnt, 32'd0);
    check_eq("rstf_hitcnt",  last_hitcnt, 32'd0);
    do_cycle(1'b0, 1'b1, 32'h40, 1'b0);
    check_eq("rstf_40_miss", {31'd0, last_ihit}, 32'd0);
    do_cycle(1'b0, 1'b1, 32'h40, 1'b0);

    // Zero-wait memory: eight sequential words, then a replay of hits.
    do_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int w = 0; w < 8; w++) begin
      a = 32'(w * 4);
      n = 0;
      last_ihit = 1'b0;
      while (!last_ihit && n < 6) begin
        do_cycle(1'b0, 1'b1, a, 1'b0);
        n++;
      end
      check_eq("zw_cycles", 32'(n), 32'd3);
    end
    check_eq("zw_misscnt", last_misscnt, 32'd8);
    for (int w = 0; w < 8; w++) begin
      do_cycle(1'b0, 1'b1, 32'(w * 4), 1'b0);
      check_eq("zw_replay_hit", {31'd0, last_ihit}, 32'd1);
    end

    // Randomized traffic over a small aliasing address pool.
    for (int r = 0; r < 3000; r++) begin
      a = ({$urandom_range(3, 0)} << 6) | ({$urandom_range(15, 0)} << 2) | {30'd0, 2'($urandom)};
      do_cycle(($urandom % 200) == 0, ($urandom % 4) != 0, a, ($urandom % 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end
endmodule
